// File: rtl/biquad_cascade.sv
// Direct-form-I cascade of second-order IIR sections sharing one
// time-multiplexed signed multiplier. Per-stage saturation with a sticky
// overflow flag, per-stage bypass and double-buffered coefficient banks.
module biquad_cascade #(
  parameter int DATA_WIDTH   = 16,
  parameter int COEFF_WIDTH  = 25,
  parameter int COEFF_FRAC   = 22,
  parameter int NUM_STAGES   = 4,
  parameter int MULT_LATENCY = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          reinit_i,
  input  logic signed [DATA_WIDTH-1:0]  data_i,
  input  logic                          data_valid_i,
  output logic signed [DATA_WIDTH-1:0]  data_o,
  output logic                          data_valid_o,
  output logic                          busy_o,
  output logic                          dropped_o,
  output logic                          overflow_o,
  input  logic [NUM_STAGES-1:0]         bypass_i,
  input  logic                          coeff_wr_i,
  input  logic [2:0]                    coeff_stage_i,
  input  logic [2:0]                    coeff_sel_i,
  input  logic signed [COEFF_WIDTH-1:0] coeff_data_i,
  input  logic                          coeff_commit_i
);

  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + 3;
  localparam int OPB_W = COEFF_WIDTH + 1;
  localparam int SW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic signed [COEFF_WIDTH-1:0] ONE     = COEFF_WIDTH'(1 << COEFF_FRAC);
  localparam logic signed [ACC_W-1:0]       SAT_MAX = ACC_W'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0]       SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, STORE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           stage_q, stage_d, stage_inc;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   byp_q;
  logic                    pending_q;

  logic signed [COEFF_WIDTH-1:0] coef_a     [NUM_STAGES][5];
  logic signed [COEFF_WIDTH-1:0] coef_s     [NUM_STAGES][5];
  logic signed [COEFF_WIDTH-1:0] shadow_nxt [NUM_STAGES][5];

  logic signed [DATA_WIDTH-1:0] x1 [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0] x2 [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0] y1 [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0] y2 [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0] stage_in;

  logic signed [DATA_WIDTH-1:0] op_a, opa_d;
  logic signed [OPB_W-1:0]      op_b, opb_d;
  logic                         op_v;
  logic signed [ACC_W-1:0]      mul, prod, acc, acc_sh;
  logic                         prod_v;
  logic signed [DATA_WIDTH-1:0] y_sat;
  logic                         clamp;

  assign stage_inc = stage_q + SW'(1);
  assign mul       = ACC_W'(op_a) * ACC_W'(op_b);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: ISSUE counts products, DRAIN counts pipeline cycles
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (data_valid_i) begin
        stage_d = '0;
        cnt_d   = '0;
        state_d = bypass_i[0] ? STORE : ISSUE;
      end
      ISSUE: if (cnt_q == 8'd4) begin
        cnt_d   = '0;
        state_d = DRAIN;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      DRAIN: if (cnt_q == 8'(MULT_LATENCY - 1)) begin
        cnt_d   = '0;
        state_d = STORE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      STORE: if (stage_q == SW'(NUM_STAGES - 1)) begin
        state_d = DONE;
      end else begin
        stage_d = stage_inc;
        state_d = byp_q[stage_inc] ? STORE : ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reinit_i) begin
      state_d = IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end
  end

  // Operand select: x terms with b coefficients, y terms with negated a
  always_comb begin
    opa_d = '0;
    opb_d = '0;
    case (cnt_q[2:0])
      3'd0: begin opa_d = stage_in;    opb_d = OPB_W'(coef_a[stage_q][0]);  end
      3'd1: begin opa_d = x1[stage_q]; opb_d = OPB_W'(coef_a[stage_q][1]);  end
      3'd2: begin opa_d = x2[stage_q]; opb_d = OPB_W'(coef_a[stage_q][2]);  end
      3'd3: begin opa_d = y1[stage_q]; opb_d = -OPB_W'(coef_a[stage_q][3]); end
      3'd4: begin opa_d = y2[stage_q]; opb_d = -OPB_W'(coef_a[stage_q][4]); end
      default: ;
    endcase
  end

  // Shadow bank including this cycle's write, so a same-cycle commit sees it
  always_comb begin
    shadow_nxt = coef_s;
    if (coeff_wr_i) begin
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        for (int unsigned c = 0; c < 5; c++) begin
          if (coeff_stage_i == 3'(s) && coeff_sel_i == 3'(c))
            shadow_nxt[s][c] = coeff_data_i;
        end
      end
    end
  end

  // Rescale and clamp the accumulated sum to the sample range
  always_comb begin
    acc_sh = acc >>> COEFF_FRAC;
    clamp  = 1'b1;
    if (acc_sh > SAT_MAX)      y_sat = DATA_WIDTH'(SAT_MAX);
    else if (acc_sh < SAT_MIN) y_sat = DATA_WIDTH'(SAT_MIN);
    else begin
      y_sat = acc_sh[DATA_WIDTH-1:0];
      clamp = 1'b0;
    end
  end

  // Multiplier output pipeline; op register counts as the first latency cycle
  if (MULT_LATENCY == 1) begin : g_comb_mul
    assign prod   = mul;
    assign prod_v = op_v;
  end else begin : g_pipe_mul
    logic signed [ACC_W-1:0] pp [MULT_LATENCY-1];
    logic [MULT_LATENCY-2:0] pv;
    // Product delay line
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < MULT_LATENCY - 1; i++) pp[i] <= '0;
        pv <= '0;
      end else if (reinit_i) begin
        pv <= '0;
      end else begin
        pp[0] <= mul;
        pv[0] <= op_v;
        for (int unsigned i = 1; i < MULT_LATENCY - 1; i++) begin
          pp[i] <= pp[i-1];
          pv[i] <= pv[i-1];
        end
      end
    end
    assign prod   = pp[MULT_LATENCY-2];
    assign prod_v = pv[MULT_LATENCY-2];
  end

  // Datapath, history, coefficient banks and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        for (int unsigned c = 0; c < 5; c++) begin
          coef_a[s][c] <= (c == 0) ? ONE : '0;
          coef_s[s][c] <= (c == 0) ? ONE : '0;
        end
        x1[s] <= '0; x2[s] <= '0; y1[s] <= '0; y2[s] <= '0;
      end
      op_a <= '0; op_b <= '0; op_v <= 1'b0;
      acc <= '0; stage_in <= '0; byp_q <= '0; pending_q <= 1'b0;
      data_o <= '0; data_valid_o <= 1'b0; busy_o <= 1'b0;
      dropped_o <= 1'b0; overflow_o <= 1'b0;
    end else if (reinit_i) begin
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        x1[s] <= '0; x2[s] <= '0; y1[s] <= '0; y2[s] <= '0;
      end
      op_v <= 1'b0; acc <= '0; stage_in <= '0; pending_q <= 1'b0;
      data_o <= '0; data_valid_o <= 1'b0; busy_o <= 1'b0;
      dropped_o <= 1'b0; overflow_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      dropped_o    <= data_valid_i && (state_q != IDLE);
      coef_s       <= shadow_nxt;
      op_v         <= (state_q == ISSUE);
      if (state_q == ISSUE) begin
        op_a <= opa_d;
        op_b <= opb_d;
      end
      if (prod_v) acc <= acc + prod;
      if (coeff_commit_i && state_q != IDLE) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (coeff_commit_i || pending_q) begin
            coef_a    <= shadow_nxt;
            pending_q <= 1'b0;
          end
          if (data_valid_i) begin
            stage_in <= data_i;
            byp_q    <= bypass_i;
            busy_o   <= 1'b1;
            acc      <= '0;
          end
        end
        STORE: begin
          if (!byp_q[stage_q]) begin
            x2[stage_q] <= x1[stage_q];
            x1[stage_q] <= stage_in;
            y2[stage_q] <= y1[stage_q];
            y1[stage_q] <= y_sat;
            stage_in    <= y_sat;
            if (clamp) overflow_o <= 1'b1;
          end
          acc <= '0;
        end
        DONE: begin
          data_o       <= stage_in;
          data_valid_o <= 1'b1;
          busy_o       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// Directed bench for biquad_cascade: latency, IIR response, saturation,
// drop handling, coefficient commit timing, bypass, reinit and reset abort.
module tb_biquad_cascade;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               reinit_i = 1'b0;
  logic signed [15:0] data_i = '0;
  logic               data_valid_i = 1'b0;
  logic signed [15:0] data_o;
  logic               data_valid_o;
  logic               busy_o;
  logic               dropped_o;
  logic               overflow_o;
  logic [3:0]         bypass_i = '0;
  logic               coeff_wr_i = 1'b0;
  logic [2:0]         coeff_stage_i = '0;
  logic [2:0]         coeff_sel_i = '0;
  logic signed [24:0] coeff_data_i = '0;
  logic               coeff_commit_i = 1'b0;

  int checks = 0;
  int failures = 0;

  localparam logic signed [24:0] C_ONE   = 25'sd4194304;
  localparam logic signed [24:0] C_TWO   = 25'sd8388608;
  localparam logic signed [24:0] C_THREE = 25'sd12582912;
  localparam logic signed [24:0] C_HALFN = -25'sd2097152;

  biquad_cascade #(
    .DATA_WIDTH(16), .COEFF_WIDTH(25), .COEFF_FRAC(22),
    .NUM_STAGES(4), .MULT_LATENCY(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .reinit_i(reinit_i),
    .data_i(data_i), .data_valid_i(data_valid_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .busy_o(busy_o),
    .dropped_o(dropped_o), .overflow_o(overflow_o), .bypass_i(bypass_i),
    .coeff_wr_i(coeff_wr_i), .coeff_stage_i(coeff_stage_i),
    .coeff_sel_i(coeff_sel_i), .coeff_data_i(coeff_data_i),
    .coeff_commit_i(coeff_commit_i)
  );

  always #5 clk_i = ~clk_i;

  // Stimulus helpers (no checking inside)
  task automatic send(input logic signed [15:0] d, input logic [3:0] byp,
                      output int lat, output logic signed [15:0] q, output int drops);
    @(negedge clk_i);
    data_i = d; bypass_i = byp; data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    lat = 0; drops = 0;
    while (!data_valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
      if (dropped_o) drops++;
    end
    q = data_o;
  endtask

  task automatic wr_coef(input logic [2:0] st, input logic [2:0] sel,
                         input logic signed [24:0] val, input logic commit);
    @(negedge clk_i);
    coeff_wr_i = 1'b1; coeff_stage_i = st; coeff_sel_i = sel;
    coeff_data_i = val; coeff_commit_i = commit;
    @(posedge clk_i); #1;
    coeff_wr_i = 1'b0; coeff_commit_i = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk_i);
    coeff_commit_i = 1'b1;
    @(posedge clk_i); #1;
    coeff_commit_i = 1'b0;
  endtask

  task automatic do_reinit();
    @(negedge clk_i);
    reinit_i = 1'b1;
    @(posedge clk_i); #1;
    reinit_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({data_valid_o, busy_o, dropped_o, overflow_o} !== 4'b0000 || data_o !== 16'sd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b o=%b data=%0d, want all 0",
               data_valid_o, busy_o, dropped_o, overflow_o, data_o);
    end
  endtask

  task automatic test_identity();
    int lat, dr; logic signed [15:0] q;
    send(16'sd1000, 4'b0000, lat, q, dr);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL ident_latency: got %0d want 33", lat); end
    checks++;
    if (q !== 16'sd1000) begin failures++; $display("FAIL ident_data: got %0d want 1000", q); end
    checks++;
    if (overflow_o !== 1'b0) begin failures++; $display("FAIL ident_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_back_to_back();
    int lat, dr; logic signed [15:0] q;
    send(-16'sd7, 4'b0000, lat, q, dr);
    checks++;
    if (lat !== 33 || q !== -16'sd7 || dr !== 0) begin
      failures++;
      $display("FAIL b2b: got lat=%0d data=%0d drops=%0d want 33 -7 0", lat, q, dr);
    end
  endtask

  task automatic test_iir();
    int lat, dr; logic signed [15:0] q;
    logic signed [15:0] xin [4] = '{16'sd1024, 16'sd0, 16'sd0, 16'sd0};
    logic signed [15:0] exp_y [4] = '{16'sd1024, 16'sd512, 16'sd256, 16'sd128};
    wr_coef(3'd0, 3'd3, C_HALFN, 1'b0);
    do_commit();
    do_reinit();
    for (int i = 0; i < 4; i++) begin
      send(xin[i], 4'b0000, lat, q, dr);
      checks++;
      if (q !== exp_y[i]) begin
        failures++;
        $display("FAIL iir_y%0d: got %0d want %0d", i, q, exp_y[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat, dr; logic signed [15:0] q;
    do_reinit();
    wr_coef(3'd0, 3'd3, 25'sd0, 1'b0);
    wr_coef(3'd0, 3'd0, C_TWO, 1'b1);
    send(16'sd20000, 4'b0000, lat, q, dr);
    checks++;
    if (q !== 16'sd32767 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos: got %0d ovf=%b want 32767 ovf=1", q, overflow_o);
    end
    send(-16'sd20000, 4'b0000, lat, q, dr);
    checks++;
    if (q !== -16'sd32768 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg: got %0d ovf=%b want -32768 ovf=1", q, overflow_o);
    end
    repeat (5) @(posedge clk_i);
    #1;
    checks++;
    if (overflow_o !== 1'b1) begin failures++; $display("FAIL sat_sticky: got %b want 1", overflow_o); end
    do_reinit();
    checks++;
    if (overflow_o !== 1'b0) begin failures++; $display("FAIL sat_clear: got %b want 0", overflow_o); end
  endtask

  task automatic test_drop();
    int drops = 0, valids = 0;
    logic signed [15:0] q = '0;
    wr_coef(3'd0, 3'd0, C_ONE, 1'b1);
    @(negedge clk_i);
    data_i = 16'sd1000; bypass_i = '0; data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      data_i = 16'sd555;
      data_valid_i = (c == 10);
      @(posedge clk_i); #1;
      if (dropped_o) drops++;
      if (data_valid_o) begin valids++; q = data_o; end
    end
    data_valid_i = 1'b0;
    checks++;
    if (drops !== 1) begin failures++; $display("FAIL drop_pulses: got %0d want 1", drops); end
    checks++;
    if (valids !== 1 || q !== 16'sd1000) begin
      failures++;
      $display("FAIL drop_result: got valids=%0d data=%0d want 1 1000", valids, q);
    end
  endtask

  task automatic test_commit_busy();
    int lat, dr, valids = 0;
    logic signed [15:0] q = '0;
    @(negedge clk_i);
    data_i = 16'sd1000; bypass_i = '0; data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      coeff_wr_i = (c == 5); coeff_commit_i = (c == 5);
      coeff_stage_i = 3'd0; coeff_sel_i = 3'd0; coeff_data_i = C_TWO;
      @(posedge clk_i); #1;
      if (data_valid_o) begin valids++; q = data_o; end
    end
    coeff_wr_i = 1'b0; coeff_commit_i = 1'b0;
    checks++;
    if (valids !== 1 || q !== 16'sd1000) begin
      failures++;
      $display("FAIL commit_old: got valids=%0d data=%0d want 1 1000", valids, q);
    end
    send(16'sd1000, 4'b0000, lat, q, dr);
    checks++;
    if (q !== 16'sd2000) begin failures++; $display("FAIL commit_new: got %0d want 2000", q); end
    wr_coef(3'd0, 3'd0, C_THREE, 1'b1);
    send(16'sd1000, 4'b0000, lat, q, dr);
    checks++;
    if (q !== 16'sd3000) begin failures++; $display("FAIL commit_same_cycle: got %0d want 3000", q); end
    wr_coef(3'd4, 3'd0, 25'sd0, 1'b1);
    send(16'sd1000, 4'b0000, lat, q, dr);
    checks++;
    if (q !== 16'sd3000) begin failures++; $display("FAIL stage_oob_ignored: got %0d want 3000", q); end
  endtask

  task automatic test_bypass();
    int lat, dr; logic signed [15:0] q;
    send(-16'sd1234, 4'b1111, lat, q, dr);
    checks++;
    if (lat !== 5 || q !== -16'sd1234) begin
      failures++;
      $display("FAIL bypass_all: got lat=%0d data=%0d want 5 -1234", lat, q);
    end
    send(16'sd1000, 4'b1110, lat, q, dr);
    checks++;
    if (lat !== 12 || q !== 16'sd3000) begin
      failures++;
      $display("FAIL bypass_partial: got lat=%0d data=%0d want 12 3000", lat, q);
    end
  endtask

  task automatic test_reinit_abort();
    int lat, dr, valids = 0; logic signed [15:0] q;
    wr_coef(3'd0, 3'd0, C_ONE, 1'b0);
    wr_coef(3'd0, 3'd3, C_HALFN, 1'b1);
    do_reinit();
    send(16'sd1000, 4'b0000, lat, q, dr);
    checks++;
    if (q !== 16'sd1000) begin failures++; $display("FAIL reinit_pre: got %0d want 1000", q); end
    @(negedge clk_i);
    data_i = 16'sd1024; bypass_i = '0; data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      reinit_i = (c == 12);
      @(posedge clk_i); #1;
      if (data_valid_o) valids++;
    end
    reinit_i = 1'b0;
    checks++;
    if (valids !== 0 || busy_o !== 1'b0 || data_o !== 16'sd0) begin
      failures++;
      $display("FAIL reinit_abort: got valids=%0d busy=%b data=%0d want 0 0 0", valids, busy_o, data_o);
    end
    send(16'sd1024, 4'b0000, lat, q, dr);
    checks++;
    if (q !== 16'sd1024) begin failures++; $display("FAIL reinit_y0: got %0d want 1024", q); end
    send(16'sd0, 4'b0000, lat, q, dr);
    checks++;
    if (q !== 16'sd512) begin failures++; $display("FAIL reinit_y1: got %0d want 512", q); end
  endtask

  task automatic test_reset_abort();
    int lat, dr, valids = 0; logic signed [15:0] q;
    @(negedge clk_i);
    data_i = 16'sd777; bypass_i = '0; data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || data_o !== 16'sd0 || data_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got busy=%b data=%0d valid=%b want 0 0 0", busy_o, data_o, data_valid_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (data_valid_o) valids++;
    end
    checks++;
    if (valids !== 0) begin failures++; $display("FAIL reset_no_valid: got %0d want 0", valids); end
    send(16'sd1000, 4'b0000, lat, q, dr);
    send(16'sd0, 4'b0000, lat, q, dr);
    checks++;
    if (q !== 16'sd0) begin failures++; $display("FAIL reset_identity: got %0d want 0", q); end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    test_identity();
    test_back_to_back();
    test_iir();
    test_saturation();
    test_drop();
    test_commit_busy();
    test_bypass();
    test_reinit_abort();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
